dmem_bytelane: RTL and testbench

Parametrised data memory for the single-cycle and pipelined MIPS cores. Replaces the word-only DMEM with byte, halfword and word loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw), a valid/ready request port, a registered read pipeline of configurable latency and response back-pressure. Sits between the core's MEM stage and the on-chip RAM array.

---
 rtl/dmem_bytelane.sv | 135 +++++++++++++
 tb/tb_dmem_bytelane.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane.sv
// Byte/half/word data memory with valid/ready request port and a 1- or 2-stage read pipeline.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned or size-11 requests as errors; otherwise they are aligned down.
module dmem_bytelane #(
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } stage_t;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic err,
                                         input logic [1:0] size, input logic sgn,
                                         input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    if (err)                 extend = 32'h0;
    else if (size == 2'b00)  extend = {{24{sgn & b[7]}}, b};
    else if (size == 2'b01)  extend = {{16{sgn & h[15]}}, h};
    else                     extend = w;
  endfunction

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-3:0] widx;
  logic              advance, acc, wr_en, out_vld, req_err;
  logic [1:0]        eff_size, eff_off;
  logic [3:0]        be;
  logic [31:0]       wlane, s1_dat;
  stage_t            req_st, s1;

  assign widx      = req_addr[ADDR_W-1:2];
  assign advance   = !out_vld || rsp_ready;
  assign req_ready = advance;
  assign acc       = req_valid && advance;

  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    eff_size = req_size;
    eff_off  = req_addr[1:0];
    req_err  = (req_size == 2'b11) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
               (req_size == 2'b01 && req_addr[0]);
`else
    eff_size = (req_size == 2'b11) ? 2'b10 : req_size;
    case (eff_size)
      2'b00:   eff_off = req_addr[1:0];
      2'b01:   eff_off = {req_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    req_err  = 1'b0;
`endif
    case (eff_size)
      2'b00:   be = 4'b0001 << eff_off;
      2'b01:   be = eff_off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (eff_size)
      2'b00:   wlane = {4{req_wdata[7:0]}};
      2'b01:   wlane = {2{req_wdata[15:0]}};
      default: wlane = req_wdata;
    endcase
  end

  // Good stores produce no response; erroring stores do, at load latency.
  assign wr_en  = acc && req_we && !req_err && !rst;
  assign req_st = '{vld: acc && (!req_we || req_err), err: req_err, size: eff_size,
                    sgn: req_signed, off: eff_off};

  // Array has no reset; read-after-write in the next cycle sees the new word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
    end
    if (acc) s1_dat <= mem[widx];
  end

  always_ff @(posedge clk) begin
    if (rst)          s1 <= '0;
    else if (advance) s1 <= req_st;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic        s2_vld, s2_err;
      logic [31:0] s2_dat;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld <= 1'b0;
          s2_err <= 1'b0;
          s2_dat <= 32'h0;
        end else if (advance) begin
          s2_vld <= s1.vld;
          s2_err <= s1.err;
          s2_dat <= extend(s1_dat, s1.err, s1.size, s1.sgn, s1.off);
        end
      end
      assign out_vld   = s2_vld;
      assign rsp_valid = s2_vld;
      assign rsp_err   = s2_vld & s2_err;
      assign rsp_rdata = s2_vld ? s2_dat : 32'h0;
    end else begin : g_lat1
      assign out_vld   = s1.vld;
      assign rsp_valid = s1.vld;
      assign rsp_err   = s1.vld & s1.err;
      assign rsp_rdata = s1.vld ? extend(s1_dat, s1.err, s1.size, s1.sgn, s1.off) : 32'h0;
    end
  endgenerate
endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane; exercises RD_LAT=1 and RD_LAT=2 instances in turn.
module tb_dmem_bytelane;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, req_valid, req_we, req_signed, rsp_ready;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rdy1, rdy2, v1, v2, e1, e2;
  logic [31:0] d1, d2;
  int          checks = 0;
  int          passed = 0;

  dmem_bytelane #(.ADDR_W(13), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1),
    .rsp_ready(rsp_ready), .rsp_rdata(d1), .rsp_err(e1));

  dmem_bytelane #(.ADDR_W(13), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy2),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v2),
    .rsp_ready(rsp_ready), .rsp_rdata(d2), .rsp_err(e2));

  assign req_ready = sel ? rdy2 : rdy1;
  assign rsp_valid = sel ? v2 : v1;
  assign rsp_rdata = sel ? d2 : d1;
  assign rsp_err   = sel ? e2 : e1;

  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [12:0] addr, input logic [31:0] wd, input logic want_rsp,
                        output logic [31:0] d, output logic e, output int lat);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    d = 32'h0; e = 1'b0; lat = 0;
    if (want_rsp) begin
      lat = 1;
      while (!rsp_valid && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      d = rsp_rdata; e = rsp_err;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid lat=%0d got %b want 0", sel + 1, rsp_valid); else passed++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata lat=%0d got %h want 0", sel + 1, rsp_rdata); else passed++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err lat=%0d got %b want 0", sel + 1, rsp_err); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready lat=%0d got %b want 1", sel + 1, req_ready); else passed++;
  endtask

  task automatic test_byte;
    logic [12:0] a_t [6] = '{13'h10, 13'h13, 13'h13, 13'h12, 13'h12, 13'h11};
    logic [1:0]  z_t [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    logic        s_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] x_t [6] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080,
                             32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
    logic [31:0] d;
    logic        e;
    int          lat;
    access(1'b1, 2'd2, 1'b0, 13'h10, 32'h80FF7F01, 1'b0, d, e, lat);
    for (int i = 0; i < 6; i++) begin
      access(1'b0, z_t[i], s_t[i], a_t[i], 32'h0, 1'b1, d, e, lat);
      checks++; if (d !== x_t[i]) $display("FAIL byte_load[%0d] lat=%0d got %h want %h", i, sel + 1, d, x_t[i]); else passed++;
      if (i == 0) begin
        checks++; if (lat !== (sel ? 2 : 1)) $display("FAIL load_latency got %0d want %0d", lat, sel ? 2 : 1); else passed++;
      end
    end
  endtask

  task automatic test_partial;
    logic [31:0] d;
    logic        e;
    int          lat;
    access(1'b1, 2'd2, 1'b0, 13'h20, 32'h11223344, 1'b0, d, e, lat);
    access(1'b1, 2'd0, 1'b0, 13'h21, 32'h123456AA, 1'b0, d, e, lat);
    access(1'b1, 2'd1, 1'b0, 13'h22, 32'h9999BEEF, 1'b0, d, e, lat);
    access(1'b0, 2'd2, 1'b0, 13'h20, 32'h0, 1'b1, d, e, lat);
    checks++; if (d !== 32'hBEEFAA44) $display("FAIL partial_write lat=%0d got %h want BEEFAA44", sel + 1, d); else passed++;
  endtask

  task automatic test_write_first;
    logic [31:0] d;
    logic        e;
    int          lat;
    access(1'b1, 2'd2, 1'b0, 13'h40, 32'hDEADBEEF, 1'b0, d, e, lat);
    access(1'b0, 2'd2, 1'b0, 13'h40, 32'h0, 1'b1, d, e, lat);
    checks++; if (d !== 32'hDEADBEEF) $display("FAIL write_first lat=%0d got %h want DEADBEEF", sel + 1, d); else passed++;
  endtask

  task automatic test_misalign;
    logic [31:0] d;
    logic        e;
    int          lat;
    access(1'b0, 2'd2, 1'b0, 13'h42, 32'h0, 1'b1, d, e, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL mis_lw lat=%0d got err=%b d=%h want err=1 d=0", sel + 1, e, d); else passed++;
    access(1'b1, 2'd1, 1'b0, 13'h41, 32'h00001234, 1'b1, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL mis_sh_rsp lat=%0d got err=%b d=%h want err=1 d=0", sel + 1, e, d); else passed++;
    access(1'b0, 2'd2, 1'b0, 13'h40, 32'h0, 1'b1, d, e, lat);
    checks++; if (e !== 1'b0 || d !== 32'hDEADBEEF) $display("FAIL mis_mem_kept lat=%0d got err=%b d=%h want DEADBEEF", sel + 1, e, d); else passed++;
    access(1'b0, 2'd3, 1'b0, 13'h40, 32'h0, 1'b1, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL size11 lat=%0d got err=%b d=%h want err=1 d=0", sel + 1, e, d); else passed++;
    access(1'b0, 2'd1, 1'b1, 13'h43, 32'h0, 1'b1, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL mis_lh lat=%0d got err=%b d=%h want err=1 d=0", sel + 1, e, d); else passed++;
`else
    checks++; if (e !== 1'b0 || d !== 32'hDEADBEEF) $display("FAIL mis_lw lat=%0d got err=%b d=%h want DEADBEEF", sel + 1, e, d); else passed++;
    access(1'b1, 2'd1, 1'b0, 13'h41, 32'h00001234, 1'b0, d, e, lat);
    access(1'b0, 2'd2, 1'b0, 13'h40, 32'h0, 1'b1, d, e, lat);
    checks++; if (e !== 1'b0 || d !== 32'hDEAD1234) $display("FAIL mis_sh_aligned lat=%0d got err=%b d=%h want DEAD1234", sel + 1, e, d); else passed++;
    access(1'b0, 2'd3, 1'b0, 13'h41, 32'h0, 1'b1, d, e, lat);
    checks++; if (e !== 1'b0 || d !== 32'hDEAD1234) $display("FAIL size11 lat=%0d got err=%b d=%h want DEAD1234", sel + 1, e, d); else passed++;
    access(1'b0, 2'd1, 1'b1, 13'h43, 32'h0, 1'b1, d, e, lat);
    checks++; if (e !== 1'b0 || d !== 32'hFFFFDEAD) $display("FAIL mis_lh lat=%0d got err=%b d=%h want FFFFDEAD", sel + 1, e, d); else passed++;
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_t [4] = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    logic [31:0] d;
    logic        e, v, acc_now, seen;
    int          lat, nis, nrx, stall, stall_seen;
    for (int i = 0; i < 4; i++)
      access(1'b1, 2'd2, 1'b0, 13'h50 + 13'(4 * i), exp_t[i], 1'b0, d, e, lat);
    nis = 0; nrx = 0; stall = 0; stall_seen = 0; seen = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    for (int c = 0; c < 40 && nrx < 4; c++) begin
      v = rsp_valid;
      if (v && !seen) begin
        seen = 1'b1;
        stall = 3;
      end
      rsp_ready = (stall == 0);
      #1;
      if (v && !rsp_ready) begin
        stall_seen++;
        checks++; if (req_ready !== 1'b0) $display("FAIL stall_ready lat=%0d got %b want 0", sel + 1, req_ready); else passed++;
        checks++; if (rsp_rdata !== exp_t[nrx] || rsp_err !== 1'b0) $display("FAIL stall_hold lat=%0d got %h want %h", sel + 1, rsp_rdata, exp_t[nrx]); else passed++;
      end else if (v) begin
        checks++; if (rsp_rdata !== exp_t[nrx]) $display("FAIL b2b_rsp[%0d] lat=%0d got %h want %h", nrx, sel + 1, rsp_rdata, exp_t[nrx]); else passed++;
        nrx++;
      end
      if (stall > 0) stall--;
      req_valid = (nis < 4);
      req_addr  = 13'h50 + 13'(4 * nis);
      acc_now   = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc_now) nis++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    checks++; if (nrx !== 4) $display("FAIL b2b_count lat=%0d got %0d want 4", sel + 1, nrx); else passed++;
    checks++; if (stall_seen !== 3) $display("FAIL b2b_stall_cycles lat=%0d got %0d want 3", sel + 1, stall_seen); else passed++;
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d;
    logic        e;
    int          lat, cnt;
    access(1'b1, 2'd2, 1'b0, 13'h60, 32'h600D600D, 1'b0, d, e, lat);
    access(1'b1, 2'd2, 1'b0, 13'h64, 32'h0BADF00D, 1'b0, d, e, lat);
    rsp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 13'h60; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 13'h64;
    @(posedge clk); #1;
    // Store presented on the reset edge must not land.
    rst = 1'b1; rsp_ready = 1'b1; req_we = 1'b1; req_addr = 13'h60; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL flush_outputs lat=%0d got v=%b d=%h e=%b want 0", sel + 1, rsp_valid, rsp_rdata, rsp_err); else passed++;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    checks++; if (cnt !== 0) $display("FAIL flush_no_rsp lat=%0d got %0d want 0", sel + 1, cnt); else passed++;
    access(1'b0, 2'd2, 1'b0, 13'h60, 32'h0, 1'b1, d, e, lat);
    checks++; if (d !== 32'h600D600D) $display("FAIL mem_retained lat=%0d got %h want 600D600D", sel + 1, d); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0;
    rsp_ready = 1'b1; req_size = 2'd0; req_addr = 13'h0; req_wdata = 32'h0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      test_reset;
      test_byte;
      test_partial;
      test_write_first;
      test_misalign;
      test_back_to_back;
      test_reset_midflight;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
